seq_mult_32b: RTL and testbench
===============================

SEQ_MULT_32B -- requirements
Module: seq_mult_32b

Interface
REQ-001 Parameters: none; operand width SHALL be fixed at 32 bits and product width at 64 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin a multiply with the current a and b.
REQ-005 a  input  32  unsigned multiplicand.
REQ-006 b  input  32  unsigned multiplier.
REQ-007 product  output  64  registered unsigned result a*b of the last completed operation.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse marking a new valid product.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-011 Start acceptance: at an edge T where start=1 and state is IDLE or DONE, the block SHALL latch a and b, clear the accumulator and iteration counter, and enter RUN.
REQ-012 start SHALL be ignored while in RUN; a and b changes after T SHALL NOT affect the result.
REQ-013 RUN SHALL use shift-add iteration, one multiplier bit per cycle, LSB first, for exactly 32 cycles (edges T+1 .. T+32).
REQ-014 Each iteration: if the current multiplier bit is 1, add the shifted multiplicand into a 64-bit accumulator; the addition SHALL NOT overflow (full 64-bit width).
REQ-015 At edge T+32 the block SHALL load product with the final accumulator value and enter DONE.
REQ-016 busy SHALL be 1 exactly in the 32 cycles following edges T .. T+31, and 0 otherwise.
REQ-017 done SHALL be 1 only in the cycle following edge T+32 (state DONE), for exactly one cycle.
REQ-018 From DONE with start=0, the block SHALL return to IDLE on the next edge.
REQ-019 From DONE with start=1, the block SHALL accept the new operation (REQ-011) and enter RUN directly, so back-to-back throughput is one result per 33 cycles.
REQ-020 product SHALL change only at completion (REQ-015) or reset, and SHALL hold its value through IDLE and through a following RUN.
REQ-021 Any operand value (0, all-ones, mixed) SHALL yield the exact unsigned product; no early termination on zero operands.
REQ-022 Latency, from the start-acceptance edge to the edge at which product becomes valid, SHALL be exactly 32 cycles; done is visible from that edge.

Reset
REQ-023 When reset=1 at an edge: state=IDLE, product=0, busy=0, done=0, accumulator, counter and latched operands=0.
REQ-024 Reset SHALL take priority over start and over any state, including mid-RUN; an in-progress operation SHALL be discarded with no done pulse.
REQ-025 After reset deasserts, start in the first cycle SHALL be accepted normally.

Verification
REQ-026 a=0x00000000, b=0xFFFFFFFF, start pulse at T -> busy for 32 cycles; done pulse after edge T+32; product=0x0000000000000000.
REQ-027 a=7, b=6 -> product=0x000000000000002A; done high exactly one cycle; busy=0 in the done cycle.
REQ-028 a=b=0xFFFFFFFF -> product=0xFFFFFFFE00000001.
REQ-029 Start a=3, b=5; at T+10 assert start with a=9, b=9 and change a/b every cycle -> second start ignored; product=0x000000000000000F at T+32.
REQ-030 Start a=0x12345678, b=0x10; assert reset at T+15 -> all outputs 0 next cycle; no done pulse; product remains 0.
REQ-031 Hold start=1 continuously with a=2, b=3 -> product=6, done pulses every 33 cycles, busy low only in done cycles.

Source files
------------

// File: rtl/seq_mult_32b.sv
// 32x32 unsigned sequential shift-add multiplier: one multiplier bit per cycle,
// 32 iterations, registered 64-bit product with busy/done handshake.
module seq_mult_32b (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] product,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_accept;
    logic        w_last;
    logic [63:0] r_mcand;
    logic [31:0] r_mplier;
    logic [63:0] r_acc;
    logic [4:0]  r_cnt;
    logic [63:0] r_product;
    logic [63:0] w_addend;
    logic [63:0] w_acc_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == 5'd31) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Multiplicand is pre-extended to 64 bits so the shifted partial product never loses bits.
    assign w_addend   = r_mplier[0] ? r_mcand : 64'd0;
    assign w_acc_next = r_acc + w_addend;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand   <= 64'd0;
            r_mplier  <= 32'd0;
            r_acc     <= 64'd0;
            r_cnt     <= 5'd0;
            r_product <= 64'd0;
        end else if (w_accept) begin
            r_mcand  <= {32'd0, a};
            r_mplier <= b;
            r_acc    <= 64'd0;
            r_cnt    <= 5'd0;
        end else if (r_state == S_RUN) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 5'd1;
            if (w_last) begin
                r_product <= w_acc_next;
            end
        end
    end

    assign product = r_product;
    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);

endmodule

// File: tb/tb_seq_mult_32b.sv
// Self-checking bench for seq_mult_32b: directed and random operands compared
// against a plain 64-bit multiply model with cycle-exact busy/done expectations.
module tb_seq_mult_32b;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] product;
    logic        busy;
    logic        done;

    int total;
    int bad;
    logic [63:0] exp_prod;

    seq_mult_32b dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .product(product),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        a     = 32'hDEADBEEF;
        b     = 32'h12345678;
        tick();
        tick();
        exp_prod = 64'd0;
        total++;
        if (product !== 64'd0) begin
            bad++;
            $display("FAIL reset_product got=%h exp=%h", product, 64'd0);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL reset_done got=%b exp=0", done);
        end
        reset = 1'b0;
        start = 1'b0;
    endtask

    // First operation starts in the very first cycle after reset release.
    task automatic test_basic();
        logic [31:0] va [16];
        logic [31:0] vb [16];
        logic [63:0] want;
        va[0] = 32'h00000000; vb[0] = 32'hFFFFFFFF;
        va[1] = 32'd7;        vb[1] = 32'd6;
        va[2] = 32'hFFFFFFFF; vb[2] = 32'hFFFFFFFF;
        va[3] = 32'hFFFFFFFF; vb[3] = 32'h00000001;
        va[4] = 32'h80000000; vb[4] = 32'h80000000;
        va[5] = 32'h12345678; vb[5] = 32'h00000000;
        for (int k = 6; k < 16; k++) begin
            va[k] = $urandom();
            vb[k] = $urandom();
        end
        for (int k = 0; k < 16; k++) begin
            start = 1'b1;
            a     = va[k];
            b     = vb[k];
            want  = 64'(va[k]) * 64'(vb[k]);
            tick();
            start = 1'b0;
            for (int i = 0; i < 32; i++) begin
                total++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    bad++;
                    $display("FAIL basic_run op=%0d cyc=%0d busy=%b done=%b exp busy=1 done=0", k, i, busy, done);
                end
                total++;
                if (product !== exp_prod) begin
                    bad++;
                    $display("FAIL basic_hold op=%0d cyc=%0d got=%h exp=%h", k, i, product, exp_prod);
                end
                a = $urandom();
                b = $urandom();
                tick();
            end
            exp_prod = want;
            total++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL basic_done op=%0d busy=%b done=%b exp busy=0 done=1", k, busy, done);
            end
            total++;
            if (product !== exp_prod) begin
                bad++;
                $display("FAIL basic_product op=%0d a=%h b=%h got=%h exp=%h", k, va[k], vb[k], product, exp_prod);
            end
            tick();
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || product !== exp_prod) begin
                bad++;
                $display("FAIL basic_idle op=%0d busy=%b done=%b prod=%h exp 0 0 %h", k, busy, done, product, exp_prod);
            end
        end
    endtask

    task automatic test_ignore_start();
        start = 1'b1;
        a     = 32'd3;
        b     = 32'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i >= 9) begin
                start = 1'b1;
                a     = $urandom();
                b     = $urandom();
            end
            total++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL ignore_run cyc=%0d busy=%b done=%b exp busy=1 done=0", i, busy, done);
            end
            tick();
        end
        exp_prod = 64'd15;
        total++;
        if (product !== exp_prod || done !== 1'b1) begin
            bad++;
            $display("FAIL ignore_product got=%h done=%b exp=%h done=1", product, done, exp_prod);
        end
        start = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL ignore_idle busy=%b done=%b exp 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_run();
        int done_seen;
        start = 1'b1;
        a     = 32'h12345678;
        b     = 32'h00000010;
        tick();
        start = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_prod = 64'd0;
        total++;
        if (product !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL midrst_outputs prod=%h busy=%b done=%b exp 0 0 0", product, busy, done);
        end
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1 || busy === 1'b1 || product !== 64'd0) done_seen++;
            tick();
        end
        total++;
        if (done_seen !== 0) begin
            bad++;
            $display("FAIL midrst_quiet bad_cycles got=%0d exp=0", done_seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] na;
        logic [31:0] nb;
        logic [63:0] want;
        start = 1'b1;
        a     = 32'd2;
        b     = 32'd3;
        want  = 64'd6;
        tick();
        for (int op = 0; op < 6; op++) begin
            if (op < 2) begin
                na = 32'd2;
                nb = 32'd3;
            end else begin
                na = $urandom();
                nb = $urandom();
            end
            for (int i = 0; i < 32; i++) begin
                total++;
                if (busy !== 1'b1 || done !== 1'b0 || product !== exp_prod) begin
                    bad++;
                    $display("FAIL b2b_run op=%0d cyc=%0d busy=%b done=%b prod=%h exp 1 0 %h", op, i, busy, done, product, exp_prod);
                end
                if (op >= 2 && i < 31) begin
                    a = $urandom();
                    b = $urandom();
                end else if (i == 31) begin
                    a = na;
                    b = nb;
                end
                tick();
            end
            exp_prod = want;
            total++;
            if (done !== 1'b1 || busy !== 1'b0 || product !== exp_prod) begin
                bad++;
                $display("FAIL b2b_done op=%0d busy=%b done=%b prod=%h exp 0 1 %h", op, busy, done, product, exp_prod);
            end
            want = 64'(na) * 64'(nb);
            if (op == 5) start = 1'b0;
            tick();
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== exp_prod) begin
            bad++;
            $display("FAIL b2b_idle busy=%b done=%b prod=%h exp 0 0 %h", busy, done, product, exp_prod);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        exp_prod = 64'd0;
        reset    = 1'b1;
        start    = 1'b0;
        a        = 32'd0;
        b        = 32'd0;
        #1;
        test_reset();
        test_basic();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
